// File: rtl/clk_pll_mgr_pkg.sv
// Shared types and helpers for the PLL clock manager: FSM state encoding and
// a compile-time max used to size the shared sequencing counter.
package clk_pll_mgr_pkg;

  typedef enum logic [1:0] {
    S_PLLRST = 2'd0,
    S_WAIT   = 2'd1,
    S_STAB   = 2'd2,
    S_RUN    = 2'd3
  } pll_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/clk_pll_mgr_if.sv
// Control/status bundle between the PLL manager and its supervisor.
// soft_rst and clr_status are sampled on every clk edge; assert them for one cycle.
interface clk_pll_mgr_if #(
  parameter int RETRY_W = 4
) ();
  import clk_pll_mgr_pkg::*;

  logic               soft_rst;
  logic               clr_status;
  logic               sys_reset_n;
  logic               locked;
  logic               lock_lost;
  logic [RETRY_W-1:0] retry_cnt;
  pll_state_e         state;

  modport master (
    output soft_rst, clr_status,
    input  sys_reset_n, locked, lock_lost, retry_cnt, state
  );

  modport slave (
    input  soft_rst, clr_status,
    output sys_reset_n, locked, lock_lost, retry_cnt, state
  );
endinterface

// File: rtl/clk_pll_mgr_rpll.sv
// Thin wrapper around the Gowin rPLL primitive with a fixed configuration.
// Outside synthesis a behavioural stand-in is elaborated instead.
module gowin_rpll_param #(
  parameter     DEVICE    = "GW1NR-9C",
  parameter     FCLKIN    = "27",
  parameter int IDIV_SEL  = 4,
  parameter int FBDIV_SEL = 0,
  parameter int ODIV_SEL  = 80,
  parameter int SDIV_SEL  = 2
) (
  input  logic clkin,
  input  logic reset,
  output logic clkout,
  output logic clkoutd,
  output logic lock
);

`ifdef SYNTHESIS
  rPLL #(
    .FCLKIN          (FCLKIN),
    .DEVICE          (DEVICE),
    .DYN_IDIV_SEL    ("false"),
    .IDIV_SEL        (IDIV_SEL),
    .DYN_FBDIV_SEL   ("false"),
    .FBDIV_SEL       (FBDIV_SEL),
    .DYN_ODIV_SEL    ("false"),
    .ODIV_SEL        (ODIV_SEL),
    .PSDA_SEL        ("0000"),
    .DYN_DA_EN       ("false"),
    .DUTYDA_SEL      ("1000"),
    .CLKOUT_FT_DIR   (1'b1),
    .CLKOUTP_FT_DIR  (1'b1),
    .CLKOUT_DLY_STEP (0),
    .CLKOUTP_DLY_STEP(0),
    .CLKFB_SEL       ("internal"),
    .CLKOUT_BYPASS   ("false"),
    .CLKOUTP_BYPASS  ("false"),
    .CLKOUTD_BYPASS  ("false"),
    .DYN_SDIV_SEL    (SDIV_SEL),
    .CLKOUTD_SRC     ("CLKOUT"),
    .CLKOUTD3_SRC    ("CLKOUT")
  ) u_rpll (
    .CLKOUT  (clkout),
    .LOCK    (lock),
    .CLKOUTP (),
    .CLKOUTD (clkoutd),
    .CLKOUTD3(),
    .RESET   (reset),
    .RESET_P (1'b0),
    .CLKIN   (clkin),
    .CLKFB   (1'b0),
    .FBDSEL  (6'd0),
    .IDSEL   (6'd0),
    .ODSEL   (6'd0),
    .PSDA    (4'd0),
    .DUTYDA  (4'd0),
    .FDLY    (4'd0)
  );
`else
  // Stand-in: output follows the reference, lock rises a fixed delay after reset.
  localparam int  HALF           = (SDIV_SEL / 2 > 0) ? SDIV_SEL / 2 : 1;
  localparam int  SIM_LOCK_DELAY = 4 + IDIV_SEL + FBDIV_SEL + ODIV_SEL / 16;
  localparam bit  CFG_VALID      = (DEVICE != "") && (FCLKIN != "");

  logic [7:0] div_cnt;
  logic       clkd_q;
  logic [7:0] lock_cnt;

  always_ff @(posedge clkin or posedge reset) begin
    if (reset) begin
      div_cnt  <= 8'd0;
      clkd_q   <= 1'b0;
      lock_cnt <= 8'd0;
    end else begin
      if (div_cnt == 8'(HALF - 1)) begin
        div_cnt <= 8'd0;
        clkd_q  <= ~clkd_q;
      end else begin
        div_cnt <= div_cnt + 8'd1;
      end
      if (lock_cnt != 8'(SIM_LOCK_DELAY)) lock_cnt <= lock_cnt + 8'd1;
    end
  end

  assign clkout  = clkin;
  assign clkoutd = clkd_q;
  assign lock    = CFG_VALID && (lock_cnt == 8'(SIM_LOCK_DELAY));
`endif

endmodule

// File: rtl/clk_pll_mgr.sv
// PLL supervisor: pulses the rPLL reset, waits for a stable lock with timeout
// and retry, and releases the system reset only while the PLL is running locked.
module clk_pll_mgr
  import clk_pll_mgr_pkg::*;
#(
  parameter     DEVICE        = "GW1NR-9C",
  parameter     FCLKIN        = "27",
  parameter int IDIV_SEL      = 4,
  parameter int FBDIV_SEL     = 0,
  parameter int ODIV_SEL      = 80,
  parameter int SDIV_SEL      = 2,
  parameter int RST_PULSE     = 16,
  parameter int LOCK_TIMEOUT  = 27000,
  parameter int STABLE_CYCLES = 2700,
  parameter int RETRY_W       = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  clk_pll_mgr_if.slave  bus,
  output logic          pll_clk,
  output logic          pll_clkd
);

  localparam int CNT_W = $clog2(max3(LOCK_TIMEOUT, STABLE_CYCLES, RST_PULSE) + 1);

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

  pll_state_e         state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_clr;
  logic               lock_meta, lock_s;
  logic               pll_reset, pll_lock;
  logic               retry_inc, lost_set;
  logic [RETRY_W-1:0] retry_q;
  logic               lock_lost_q, sys_rst_n_q, locked_q;

  gowin_rpll_param #(
    .DEVICE   (DEVICE),
    .FCLKIN   (FCLKIN),
    .IDIV_SEL (IDIV_SEL),
    .FBDIV_SEL(FBDIV_SEL),
    .ODIV_SEL (ODIV_SEL),
    .SDIV_SEL (SDIV_SEL)
  ) u_pll (
    .clkin  (clk),
    .reset  (pll_reset),
    .clkout (pll_clk),
    .clkoutd(pll_clkd),
    .lock   (pll_lock)
  );

  // LOCK comes from the PLL's own timing domain; only lock_s is used below.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_lock;
      lock_s    <= lock_meta;
    end
  end

  always_comb begin
    state_nx  = state;
    retry_inc = 1'b0;
    lost_set  = 1'b0;
    if (bus.soft_rst) begin
      state_nx = S_PLLRST;
    end else begin
      case (state)
        S_PLLRST: if (cnt == RST_LAST) state_nx = S_WAIT;
        S_WAIT: begin
          if (lock_s) begin
            state_nx = S_STAB;
          end else if (cnt == TO_LAST) begin
            state_nx  = S_PLLRST;
            retry_inc = 1'b1;
          end
        end
        S_STAB: begin
          if (!lock_s)               state_nx = S_WAIT;
          else if (cnt == STAB_LAST) state_nx = S_RUN;
        end
        S_RUN: begin
          if (!lock_s) begin
            state_nx = S_PLLRST;
            lost_set = 1'b1;
          end
        end
        default: state_nx = S_PLLRST;
      endcase
    end
  end

  // A soft reset restarts the pulse even when already in PLLRST.
  assign cnt_clr = bus.soft_rst || (state_nx != state);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_PLLRST;
      cnt         <= '0;
      retry_q     <= '0;
      lock_lost_q <= 1'b0;
      sys_rst_n_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (cnt_clr)             cnt <= '0;
      else if (state != S_RUN) cnt <= cnt + 1'b1;

      if (retry_inc) begin
        if (retry_q != RETRY_MAX) retry_q <= retry_q + 1'b1;
      end else if (bus.clr_status) begin
        retry_q <= '0;
      end

      if (lost_set)            lock_lost_q <= 1'b1;
      else if (bus.clr_status) lock_lost_q <= 1'b0;

      sys_rst_n_q <= (state_nx == S_RUN);
      locked_q    <= (state_nx == S_RUN);
    end
  end

  assign pll_reset       = (state == S_PLLRST);
  assign bus.sys_reset_n = sys_rst_n_q;
  assign bus.locked      = locked_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.retry_cnt   = retry_q;
  assign bus.state       = state;

endmodule

// File: tb/tb_clk_pll_mgr.sv
// Directed bench for clk_pll_mgr with a small sequencing configuration; the
// PLL lock is driven from the bench to model lock, no-lock, glitch and loss.
module tb_clk_pll_mgr;
  import clk_pll_mgr_pkg::*;

  localparam int RETRY_W = 2;

  logic clk;
  logic reset_n;
  logic pll_clk, pll_clkd;
  logic lock_drv;

  int total;
  int passed;
  logic [31:0] exp_q[$];

  clk_pll_mgr_if #(.RETRY_W(RETRY_W)) bus ();

  clk_pll_mgr #(
    .RST_PULSE    (4),
    .LOCK_TIMEOUT (20),
    .STABLE_CYCLES(8),
    .RETRY_W      (RETRY_W)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .pll_clk (pll_clk),
    .pll_clkd(pll_clkd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial force dut.pll_lock = lock_drv;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic chk_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) passed++;
    else $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
  endtask

  // Lock asserts dly sampled cycles after the PLL reset is seen low.
  task automatic run_to_run(input int dly, output int n, output bit ok);
    int since;
    lock_drv = 1'b0;
    since = 0;
    n = 0;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      n++;
      if (dut.pll_reset) since = 0;
      else begin
        since++;
        if (since == dly) lock_drv = 1'b1;
      end
      if (bus.sys_reset_n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_state(input pll_state_e st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.state == st) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int n, w, t, last, rises;
    bit ok, prev, cur;
    logic [31:0] exp_r;

    total = 0;
    passed = 0;
    reset_n = 1'b0;
    lock_drv = 1'b0;
    bus.soft_rst = 1'b0;
    bus.clr_status = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_state", bus.state, S_PLLRST);
    chk("rst_sys_reset_n", bus.sys_reset_n, 0);
    chk("rst_locked", bus.locked, 0);
    chk("rst_lock_lost", bus.lock_lost, 0);
    chk("rst_retry", bus.retry_cnt, 0);
    chk("rst_pll_reset", dut.pll_reset, 1);

    // Reset release to RUN: 4 + 5 + 2 + 8 cycles, one cycle of registering slack
    reset_n = 1'b1;
    run_to_run(5, n, ok);
    chk("boot_reached", ok, 1);
    chk_range("boot_latency", n, 18, 20);
    chk("boot_locked", bus.locked, 1);
    chk("boot_state", bus.state, S_RUN);
    chk("boot_pll_reset", dut.pll_reset, 0);
    chk("boot_lock_lost", bus.lock_lost, 0);

    // Soft reset in RUN with lock still high
    bus.soft_rst = 1'b1;
    @(negedge clk);
    bus.soft_rst = 1'b0;
    chk("soft_state", bus.state, S_PLLRST);
    chk("soft_sys_reset_n", bus.sys_reset_n, 0);
    chk("soft_locked", bus.locked, 0);
    chk("soft_lock_lost", bus.lock_lost, 0);

    // One-cycle lock glitch during STAB
    wait_state(S_STAB, 20, ok);
    chk("glitch_reach_stab", ok, 1);
    repeat (3) @(negedge clk);
    lock_drv = 1'b0;
    @(negedge clk);
    lock_drv = 1'b1;
    n = 1;
    while (!bus.sys_reset_n && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 3) chk("glitch_back_to_wait", bus.state, S_WAIT);
    end
    chk_range("glitch_restart_latency", n, 11, 13);
    chk("glitch_run", bus.state, S_RUN);

    // Lock loss in RUN
    lock_drv = 1'b0;
    n = 0;
    while (bus.sys_reset_n && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk_range("loss_deassert_latency", n, 1, 3);
    chk("loss_lock_lost", bus.lock_lost, 1);
    chk("loss_locked", bus.locked, 0);
    chk("loss_state", bus.state, S_PLLRST);
    w = 0;
    while (dut.pll_reset === 1'b1 && w < 20) begin
      w++;
      @(negedge clk);
    end
    chk("loss_reset_width", w, 4);
    run_to_run(5, n, ok);
    chk("relock_reached", ok, 1);
    chk("relock_lock_lost", bus.lock_lost, 1);
    chk("relock_retry", bus.retry_cnt, 0);

    bus.clr_status = 1'b1;
    @(negedge clk);
    bus.clr_status = 1'b0;
    chk("clr_lock_lost", bus.lock_lost, 0);
    chk("clr_locked", bus.locked, 1);

    // No lock at all: periodic retries, counter saturates
    bus.soft_rst = 1'b1;
    lock_drv = 1'b0;
    @(negedge clk);
    bus.soft_rst = 1'b0;
    wait_state(S_WAIT, 20, ok);
    chk("nolock_reach_wait", ok, 1);
    exp_r = 0;
    for (int i = 0; i < 4; i++) begin
      exp_r = (exp_r == 3) ? 32'd3 : exp_r + 1;
      exp_q.push_back(exp_r);
    end
    prev = 1'b0;
    rises = 0;
    t = 0;
    last = -1;
    while (rises < 4 && t < 200) begin
      @(negedge clk);
      t++;
      cur = dut.pll_reset;
      if (cur && !prev) begin
        chk("retry_seq", bus.retry_cnt, exp_q.pop_front());
        if (last >= 0) chk("retry_period", t - last, 24);
        last = t;
        rises++;
      end
      prev = cur;
    end
    chk("retry_rises", rises, 4);
    chk("retry_locked", bus.locked, 0);

    // Clear on its own, then clear coinciding with a timeout increment
    bus.clr_status = 1'b1;
    @(negedge clk);
    bus.clr_status = 1'b0;
    chk("clr_retry", bus.retry_cnt, 0);
    repeat (22) @(negedge clk);
    bus.clr_status = 1'b1;
    @(negedge clk);
    bus.clr_status = 1'b0;
    chk("clr_vs_inc_retry", bus.retry_cnt, 1);
    chk("clr_vs_inc_pll_reset", dut.pll_reset, 1);

    // Asynchronous reset mid-WAIT
    repeat (6) @(negedge clk);
    chk("async_pre_state", bus.state, S_WAIT);
    #2 reset_n = 1'b0;
    #1;
    chk("async_state", bus.state, S_PLLRST);
    chk("async_retry", bus.retry_cnt, 0);
    chk("async_sys_reset_n", bus.sys_reset_n, 0);
    chk("async_pll_reset", dut.pll_reset, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("restart_pllrst", bus.state, S_PLLRST);
    @(negedge clk);
    chk("restart_wait", bus.state, S_WAIT);
    run_to_run(5, n, ok);
    chk("restart_run", ok, 1);
    chk("restart_locked", bus.locked, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", passed, total + 1);
    $fatal(1, "watchdog");
  end

endmodule
